// File: rtl/posit_sign_pipe.sv
// rtl/posit_sign_pipe.sv - two-stage posit sign unit (pass/abs/negate/nabs) with NaR/zero classification
// Valid/ready pipeline with full backpressure and a saturating NaR operand counter.
module posit_sign_pipe #(
  parameter int N     = 8,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_posit,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_nar,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNT_W-1:0] nar_count
);

  localparam logic [N-1:0]     NAR     = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]     ONE_N   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s1_valid_q, s1_valid_d;
  logic [N-1:0]     s1_posit_q, s1_posit_d;
  logic [1:0]       s1_mode_q, s1_mode_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_nar_q, s1_nar_d;
  logic             s1_zero_q, s1_zero_d;
  logic             s1_sign_q, s1_sign_d;

  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_nar_q, out_nar_d;
  logic             out_zero_q, out_zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_ready, s1_ready, in_fire, in_is_nar;
  logic [N-1:0]     neg_x, result;

  assign s2_ready  = !out_valid_q || out_ready;
  assign s1_ready  = !s1_valid_q || s2_ready;
  assign in_ready  = s1_ready;
  assign in_fire   = in_valid && s1_ready;
  assign in_is_nar = (in_posit == NAR);

  assign neg_x = ~s1_posit_q + ONE_N;

  // Special classes are forced so the result never depends on the two's-complement corner.
  always_comb begin
    result = s1_posit_q;
    case (s1_mode_q)
      2'b00:   result = s1_posit_q;
      2'b01:   result = s1_sign_q ? neg_x : s1_posit_q;
      2'b10:   result = neg_x;
      default: result = s1_sign_q ? s1_posit_q : neg_x;
    endcase
    if (s1_nar_q)       result = NAR;
    else if (s1_zero_q) result = '0;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_posit_d = s1_posit_q;
    s1_mode_d  = s1_mode_q;
    s1_tag_d   = s1_tag_q;
    s1_nar_d   = s1_nar_q;
    s1_zero_d  = s1_zero_q;
    s1_sign_d  = s1_sign_q;
    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_posit_d = in_posit;
        s1_mode_d  = in_mode;
        s1_tag_d   = in_tag;
        s1_nar_d   = in_is_nar;
        s1_zero_d  = (in_posit == '0);
        s1_sign_d  = in_posit[N-1];
      end
    end
  end

  // Output registers only load on a real transfer so they keep the last result across bubbles.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_nar_d    = out_nar_q;
    out_zero_d   = out_zero_q;
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_result_d = result;
        out_tag_d    = s1_tag_q;
        out_nar_d    = s1_nar_q;
        out_zero_d   = s1_zero_q;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (in_fire && in_is_nar && (cnt_q != CNT_MAX)) cnt_d = cnt_q + ONE_C;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_posit_q   <= '0;
      s1_mode_q    <= '0;
      s1_tag_q     <= '0;
      s1_nar_q     <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_sign_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_nar_q    <= 1'b0;
      out_zero_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_posit_q   <= s1_posit_d;
      s1_mode_q    <= s1_mode_d;
      s1_tag_q     <= s1_tag_d;
      s1_nar_q     <= s1_nar_d;
      s1_zero_q    <= s1_zero_d;
      s1_sign_q    <= s1_sign_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_nar_q    <= out_nar_d;
      out_zero_q   <= out_zero_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_nar    = out_nar_q;
  assign out_zero   = out_zero_q;
  assign out_neg    = out_result_q[N-1];
  assign nar_count  = cnt_q;

endmodule

// File: tb/tb_posit_sign_pipe.sv
// tb/tb_posit_sign_pipe.sv - self-checking bench for posit_sign_pipe
// Directed table, backpressure/reset sequences, random scoreboard run, and an N=16/CNT_W=2 instance.
module tb_posit_sign_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_posit, out_result;
  logic [1:0] in_mode;
  logic [3:0] in_tag, out_tag;
  logic       out_nar, out_zero, out_neg;
  logic [15:0] nar_count;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [15:0] w_in_posit, w_out_result;
  logic [1:0]  w_in_mode;
  logic [3:0]  w_in_tag, w_out_tag;
  logic        w_out_nar, w_out_zero, w_out_neg;
  logic [1:0]  w_nar_count;

  posit_sign_pipe #(.N(8), .TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_posit(in_posit), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .out_nar(out_nar), .out_zero(out_zero), .out_neg(out_neg), .nar_count(nar_count)
  );

  posit_sign_pipe #(.N(16), .TAG_W(4), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_posit(w_in_posit), .in_mode(w_in_mode), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_result(w_out_result), .out_tag(w_out_tag),
    .out_nar(w_out_nar), .out_zero(w_out_zero), .out_neg(w_out_neg), .nar_count(w_nar_count)
  );

  typedef struct packed {
    logic [7:0] posit;
    logic [1:0] mode;
    logic [7:0] res;
    logic       nar;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [3:0] tag;
    logic       nar;
    logic       zero;
    int         t;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  vec_t tab[22];
  int   n_cmp = 0, n_fail = 0, cyc = 0, model_cnt = 0, n_deliv = 0;
  bit   chk_lat = 0;
  bit   s_acc;
  logic s_in_ready;
  bit   hold_q = 0;
  logic [13:0] hold_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: interpret the posit as a signed integer and apply the sign operation arithmetically.
  function automatic exp_t model(input logic [7:0] p, input logic [1:0] m, input logic [3:0] tg);
    exp_t e;
    int v, mag, r;
    v   = (p >= 8'h80) ? int'(p) - 256 : int'(p);
    mag = (v < 0) ? -v : v;
    case (m)
      2'd0:    r = v;
      2'd1:    r = mag;
      2'd2:    r = -v;
      default: r = -mag;
    endcase
    e.res  = r[7:0];
    e.nar  = (p == 8'h80);
    e.zero = (p == 8'h00);
    if (e.nar) e.res = 8'h80;
    e.tag  = tg;
    e.t    = 0;
    return e;
  endfunction

  task automatic cycle();
    exp_t e;
    #2;
    s_in_ready = in_ready;
    s_acc      = in_valid && in_ready;
    if (!rst_n) begin
      sb.delete();
      model_cnt = 0;
    end else begin
      if (hold_q && out_valid)
        chk("hold_stable", 32'({out_result, out_tag, out_nar, out_zero}), 32'(hold_val));
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got result 0x%0h with no operand outstanding", out_result);
        end else begin
          e = sb.pop_front();
          chk("result", 32'(out_result), 32'(e.res));
          chk("tag", 32'(out_tag), 32'(e.tag));
          chk("nar", 32'(out_nar), 32'(e.nar));
          chk("zero", 32'(out_zero), 32'(e.zero));
          chk("neg", 32'(out_neg), 32'(e.res[7]));
          if (chk_lat) chk("latency", 32'(cyc - e.t), 32'd2);
        end
        n_deliv++;
      end
      if (s_acc) begin
        e   = cur_exp;
        e.t = cyc;
        sb.push_back(e);
        if (in_posit == 8'h80 && model_cnt < 65535) model_cnt++;
      end
    end
    hold_q   = rst_n && out_valid && !out_ready;
    hold_val = {out_result, out_tag, out_nar, out_zero};
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() > 0 && guard < 20) begin
      cycle();
      guard++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int i, c, d0;
    logic [7:0] p;
    logic [1:0] m;
    logic [3:0] tg;

    tab[0]  = '{8'h76, 2'd1, 8'h76, 1'b0, 1'b0};
    tab[1]  = '{8'h16, 2'd1, 8'h16, 1'b0, 1'b0};
    tab[2]  = '{8'h57, 2'd1, 8'h57, 1'b0, 1'b0};
    tab[3]  = '{8'h8a, 2'd1, 8'h76, 1'b0, 1'b0};
    tab[4]  = '{8'hea, 2'd1, 8'h16, 1'b0, 1'b0};
    tab[5]  = '{8'ha9, 2'd1, 8'h57, 1'b0, 1'b0};
    tab[6]  = '{8'h8a, 2'd0, 8'h8a, 1'b0, 1'b0};
    tab[7]  = '{8'h8a, 2'd1, 8'h76, 1'b0, 1'b0};
    tab[8]  = '{8'h8a, 2'd2, 8'h76, 1'b0, 1'b0};
    tab[9]  = '{8'h8a, 2'd3, 8'h8a, 1'b0, 1'b0};
    tab[10] = '{8'h30, 2'd0, 8'h30, 1'b0, 1'b0};
    tab[11] = '{8'h30, 2'd1, 8'h30, 1'b0, 1'b0};
    tab[12] = '{8'h30, 2'd2, 8'hd0, 1'b0, 1'b0};
    tab[13] = '{8'h30, 2'd3, 8'hd0, 1'b0, 1'b0};
    tab[14] = '{8'h80, 2'd0, 8'h80, 1'b1, 1'b0};
    tab[15] = '{8'h80, 2'd1, 8'h80, 1'b1, 1'b0};
    tab[16] = '{8'h80, 2'd2, 8'h80, 1'b1, 1'b0};
    tab[17] = '{8'h80, 2'd3, 8'h80, 1'b1, 1'b0};
    tab[18] = '{8'h00, 2'd0, 8'h00, 1'b0, 1'b1};
    tab[19] = '{8'h00, 2'd1, 8'h00, 1'b0, 1'b1};
    tab[20] = '{8'h00, 2'd2, 8'h00, 1'b0, 1'b1};
    tab[21] = '{8'h00, 2'd3, 8'h00, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_posit = '0; in_mode = '0; in_tag = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_in_posit = '0; w_in_mode = '0; w_in_tag = '0;
    cur_exp = model(8'h00, 2'd0, 4'd0);
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_flags", 32'({out_nar, out_zero, out_neg}), 32'd0);
    chk("rst_nar_count", 32'(nar_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table, back-to-back at full throughput.
    chk_lat = 1;
    for (int k = 0; k < 22; k++) begin
      in_valid = 1'b1;
      in_posit = tab[k].posit;
      in_mode  = tab[k].mode;
      in_tag   = 4'(k);
      cur_exp.res  = tab[k].res;
      cur_exp.tag  = 4'(k);
      cur_exp.nar  = tab[k].nar;
      cur_exp.zero = tab[k].zero;
      cycle();
      chk("table_accept", 32'(s_acc), 32'd1);
    end
    drain("table_drained");
    chk("nar_count_specials", 32'(nar_count), 32'd4);
    chk_lat = 0;

    // Backpressure: out_ready low on cycles 3..8 of a 5-operand stream.
    d0 = n_deliv; i = 0; c = 0;
    while ((i < 5 || sb.size() > 0) && c < 60) begin
      out_ready = !(c >= 3 && c <= 8);
      if (i < 5) begin
        in_valid = 1'b1;
        p = 8'($urandom); m = 2'($urandom); tg = 4'(i + 3);
        if (!s_acc || c == 0) begin
          in_posit = p; in_mode = m; in_tag = tg;
          cur_exp = model(p, m, tg);
        end
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      if (s_acc) i++;
      if (c == 6) chk("bp_in_ready_low", 32'(s_in_ready), 32'd0);
      c++;
    end
    chk("bp_all_sent", 32'(i), 32'd5);
    chk("bp_all_delivered", 32'(n_deliv - d0), 32'd5);
    drain("bp_drained");

    // Reset with both stages full.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_posit = 8'h80; in_mode = 2'd1; in_tag = 4'(k);
      cur_exp = model(8'h80, 2'd1, 4'(k));
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("full_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_nar_count", 32'(nar_count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_result", 32'(out_result), 32'd0);
    chk_lat = 1;
    d0 = n_deliv;
    in_valid = 1'b1; in_posit = 8'hc4; in_mode = 2'd2; in_tag = 4'd9;
    cur_exp = model(8'hc4, 2'd2, 4'd9);
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("midrst_followup_delivered", 32'(n_deliv - d0), 32'd1);
    chk_lat = 0;
    drain("midrst_drained");

    // Randomised traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      if (!(in_valid && !s_in_ready)) begin
        case ($urandom_range(0, 9))
          0:       p = 8'h80;
          1:       p = 8'h00;
          default: p = 8'($urandom);
        endcase
        m = 2'($urandom); tg = 4'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
        in_posit = p; in_mode = m; in_tag = tg;
        cur_exp = model(p, m, tg);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain("random_drained");
    chk("random_nar_count", 32'(nar_count), 32'(model_cnt));

    // Wide instance: N=16, CNT_W=2.
    w_in_valid = 1'b1; w_in_posit = 16'hc000; w_in_mode = 2'd1; w_in_tag = 4'd5;
    cycle();
    w_in_valid = 1'b0;
    cycle();
    chk("w16_abs_valid", 32'(w_out_valid), 32'd1);
    chk("w16_abs_c000", 32'(w_out_result), 32'h4000);
    chk("w16_abs_tag", 32'(w_out_tag), 32'd5);
    w_in_valid = 1'b1; w_in_posit = 16'h8000; w_in_tag = 4'd6;
    cycle();
    w_in_valid = 1'b0;
    cycle();
    chk("w16_abs_8000", 32'(w_out_result), 32'h8000);
    chk("w16_nar_flag", 32'(w_out_nar), 32'd1);
    chk("w16_count_one", 32'(w_nar_count), 32'd1);
    w_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    w_in_valid = 1'b0;
    cycle();
    cycle();
    chk("w16_count_saturated", 32'(w_nar_count), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
